// File: rtl/pulse_width_meter_if.sv
// Edge-strobe inputs and result handshake of pulse_width_meter.
// master = the meter (produces results), slave = synchroniser/consumer side.
interface pulse_width_meter_if #(
  parameter int COUNT_WIDTH = 24
) ();
  logic                   rising_edge;
  logic                   falling_edge;
  logic                   result_ready;
  logic [COUNT_WIDTH-1:0] width;
  logic                   width_valid;
  logic                   timeout;
  logic                   overrun;
  logic                   busy;
  logic [COUNT_WIDTH-1:0] period;
  logic                   period_valid;

  modport master (
    input  rising_edge, falling_edge, result_ready,
    output width, width_valid, timeout, overrun, busy, period, period_valid
  );

  modport slave (
    output rising_edge, falling_edge, result_ready,
    input  width, width_valid, timeout, overrun, busy, period, period_valid
  );
endinterface

// File: rtl/pulse_width_meter.sv
// Measures pulse high time in cycles from edge strobes, with timeout and valid/ready result.
// Optional rising-to-rising period measurement enabled by PULSE_WIDTH_METER_PERIOD_EN.
module pulse_width_meter #(
  parameter int COUNT_WIDTH    = 24,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  pulse_width_meter_if.master  bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;

  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_VAL = COUNT_WIDTH'(TIMEOUT_CYCLES);

  logic [1:0]             state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] width_q, width_d;
  logic                   timeout_q, timeout_d;
  logic                   overrun_q, overrun_d;
  logic                   valid_q;
  logic                   busy_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    width_d   = width_q;
    timeout_d = timeout_q;
    overrun_d = overrun_q;
    case (state_q)
      S_IDLE: begin
        // Coincident edges are a glitch shorter than the synchroniser can resolve.
        if (bus.rising_edge && !bus.falling_edge) begin
          state_d = S_MEASURE;
          count_d = COUNT_WIDTH'(1);
        end
      end
      S_MEASURE: begin
        if (bus.falling_edge) begin
          width_d   = count_q;
          timeout_d = 1'b0;
          state_d   = S_HOLD;
        end else if (count_q == TIMEOUT_VAL) begin
          width_d   = TIMEOUT_VAL;
          timeout_d = 1'b1;
          state_d   = S_HOLD;
        end else begin
          count_d = count_q + COUNT_WIDTH'(1);
        end
      end
      S_HOLD: begin
        if (bus.result_ready) begin
          state_d   = S_IDLE;
          overrun_d = 1'b0;
        end
        // A dropped edge must stay visible even when it coincides with the handshake.
        if (bus.rising_edge) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      width_q   <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      width_q   <= width_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
      valid_q   <= (state_d == S_HOLD);
      busy_q    <= (state_d == S_MEASURE);
    end
  end

  assign bus.width       = width_q;
  assign bus.timeout     = timeout_q;
  assign bus.overrun     = overrun_q;
  assign bus.width_valid = valid_q;
  assign bus.busy        = busy_q;

`ifdef PULSE_WIDTH_METER_PERIOD_EN
  localparam logic [COUNT_WIDTH-1:0] PCOUNT_MAX = '1;

  logic [COUNT_WIDTH-1:0] pcount_q, pcount_d;
  logic [COUNT_WIDTH-1:0] period_q, period_d;
  logic                   seen_q, seen_d;
  logic                   pvalid_q, pvalid_d;

  always_comb begin
    pcount_d = (pcount_q == PCOUNT_MAX) ? pcount_q : pcount_q + COUNT_WIDTH'(1);
    period_d = period_q;
    seen_d   = seen_q;
    pvalid_d = 1'b0;
    if (bus.rising_edge) begin
      pcount_d = COUNT_WIDTH'(1);
      seen_d   = 1'b1;
      // The first edge only arms the counter; there is no earlier edge to measure from.
      if (seen_q) begin
        period_d = pcount_q;
        pvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pcount_q <= '0;
      period_q <= '0;
      seen_q   <= 1'b0;
      pvalid_q <= 1'b0;
    end else begin
      pcount_q <= pcount_d;
      period_q <= period_d;
      seen_q   <= seen_d;
      pvalid_q <= pvalid_d;
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = pvalid_q;
`else
  assign bus.period       = '0;
  assign bus.period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_width_meter.sv
// Scoreboard bench for pulse_width_meter: event-level reference model feeds a per-cycle queue.
// Period expectations follow PULSE_WIDTH_METER_PERIOD_EN the same way as the design.
module tb_pulse_width_meter;
  localparam int W = 16;
  localparam int T = 50;
  localparam longint CMAX = (64'd1 << W) - 1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pulse_width_meter_if #(.COUNT_WIDTH(W)) bus ();

  pulse_width_meter #(.COUNT_WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic         valid;
    logic         busy;
    logic         ovr;
    logic         pv;
    logic [W-1:0] per;
    logic         chk_data;
    logic [W-1:0] width;
    logic         to;
  } exp_t;

  exp_t expq[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pulse described by the cycle index of its edges.
  int           k = 0;
  bit           m_meas, m_hold, m_ovr, m_to, m_seen, m_pv, m_rst;
  int           m_start, m_last;
  logic [W-1:0] m_width, m_per;

  task automatic step(input bit rst_n_v, input bit re, input bit fe, input bit rdy);
    exp_t e;
    reset_n          = rst_n_v;
    bus.rising_edge  = re;
    bus.falling_edge = fe;
    bus.result_ready = rdy;
    if (!rst_n_v) begin
      m_meas = 0; m_hold = 0; m_ovr = 0; m_to = 0; m_seen = 0; m_pv = 0;
      m_width = '0; m_per = '0; m_rst = 1;
    end else begin
      m_rst = 0;
`ifdef PULSE_WIDTH_METER_PERIOD_EN
      m_pv = 0;
      if (re) begin
        if (m_seen) begin
          m_per = W'((longint'(k - m_last) > CMAX) ? CMAX : longint'(k - m_last));
          m_pv  = 1;
        end
        m_seen = 1;
        m_last = k;
      end
`endif
      if (m_hold) begin
        if (rdy) begin
          m_hold = 0;
          m_ovr  = 0;
        end
        if (re) m_ovr = 1;
      end else if (m_meas) begin
        if (fe) begin
          m_width = W'(k - m_start); m_to = 0; m_meas = 0; m_hold = 1;
        end else if (k - m_start == T) begin
          m_width = W'(T); m_to = 1; m_meas = 0; m_hold = 1;
        end
      end else if (re && !fe) begin
        m_meas  = 1;
        m_start = k;
      end
    end
    e.valid = m_hold; e.busy = m_meas; e.ovr = m_ovr; e.pv = m_pv; e.per = m_per;
    e.chk_data = m_hold || m_rst; e.width = m_width; e.to = m_to;
    expq.push_back(e);
    @(negedge clk);
    k++;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1, 0, 0, rdy);
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Monitor: compares the DUT state after each posedge with the queued expectation.
  initial begin : monitor
    exp_t e;
    logic prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("width_valid", bus.width_valid, e.valid);
        chk("busy", bus.busy, e.busy);
        chk("overrun", bus.overrun, e.ovr);
        chk("period_valid", bus.period_valid, e.pv);
        chk("period", bus.period, e.per);
        if (e.chk_data) begin
          chk("width", bus.width, e.width);
          chk("timeout", bus.timeout, e.to);
        end
        if (bus.width_valid && !prev_valid)
          $display("[TB] result width=%0d timeout=%0d (expected %0d/%0d)",
                   bus.width, bus.timeout, e.width, e.to);
        prev_valid = bus.width_valid;
      end
    end
  end

  initial begin : stimulus
    step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    // Plain width of 100 with ready held high.
    idle(6, 1);
    step(1, 1, 0, 1); idle(99, 1); step(1, 0, 1, 1); idle(5, 1);
    // Timeout, then a late falling edge while held.
    step(1, 1, 0, 0); idle(60, 0); step(1, 0, 1, 0); idle(2, 0); idle(3, 1);
    // Hold with a dropped rising edge, then handshake.
    step(1, 1, 0, 0); idle(19, 0); step(1, 0, 1, 0); idle(3, 0);
    step(1, 1, 0, 0); idle(3, 0); step(1, 0, 0, 1); idle(3, 0);
    // Rising coincident with the handshake sets overrun.
    idle(2, 1); step(1, 1, 0, 0); step(1, 0, 1, 0); step(1, 1, 0, 1); idle(3, 0); idle(2, 1);
    // Boundaries: glitch, width 1, falling on the timeout cycle.
    step(1, 1, 1, 1); idle(3, 1);
    step(1, 1, 0, 1); step(1, 0, 1, 1); idle(3, 1);
    step(1, 1, 0, 1); idle(T - 1, 1); step(1, 0, 1, 1); idle(3, 1);
    // Reset in the middle of a measurement, then a fresh pair.
    step(1, 1, 0, 1); idle(10, 1); step(0, 0, 1, 1); idle(2, 1);
    step(1, 1, 0, 1); idle(7, 1); step(1, 0, 1, 1); idle(3, 1);
    // Period: rising edges 200 apart after a reset.
    step(0, 0, 0, 1); idle(3, 1);
    step(1, 1, 0, 1); idle(199, 1); step(1, 1, 0, 1); idle(199, 1); step(1, 1, 0, 1); idle(5, 1);
    // Randomised strobes, handshakes and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 399) != 0),
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 9) < 3));
    end
    @(negedge clk);
    #1;
    chk("queue_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_width_meter.md
# pulse_width_meter

Measures the high time of a synchronised external pulse (ultrasonic echo, wheel-encoder tick) in clock cycles. Sits directly downstream of the edge-detect synchroniser and consumes its one-cycle `rising_edge`/`falling_edge` strobes. Presents each measurement on a valid/ready handshake to the rover control logic. Long pulses are cut off by a timeout.

## Interface
- `COUNT_WIDTH`, 24: width of the width counter and the `width` output.
- `TIMEOUT_CYCLES`, 2_500_000: maximum measurable width in cycles. Must satisfy `TIMEOUT_CYCLES < 2**COUNT_WIDTH`.
- `clock` input 1: single clock (100 MHz); all logic on posedge.
- `reset_n` input 1: reset, synchronous, active-low.
- `rising_edge` input 1: one-cycle strobe from the synchroniser.
- `falling_edge` input 1: one-cycle strobe from the synchroniser.
- `result_ready` input 1: consumer accepts the result.
- `width` output COUNT_WIDTH: measured high time in cycles; held stable while `width_valid` is high.
- `width_valid` output 1: a result is available.
- `timeout` output 1: the result is a timeout; qualified by `width_valid`.
- `overrun` output 1: sticky; a rising edge was dropped while a result was held.
- `busy` output 1: high in MEASURE.
- `period` output COUNT_WIDTH: rising-to-rising period (see Configuration).
- `period_valid` output 1: one-cycle strobe when `period` updates.

## Operation
- States: IDLE, MEASURE, HOLD.
- IDLE:
  - `rising_edge` alone -> MEASURE, counter <= 1.
  - `rising_edge` and `falling_edge` in the same cycle: treat as a glitch and stay in IDLE.
  - `falling_edge` alone is ignored.
- MEASURE, each cycle:
  - `falling_edge` -> `width` <= counter, `timeout` <= 0, go to HOLD.
  - Otherwise, if counter == TIMEOUT_CYCLES -> `width` <= TIMEOUT_CYCLES, `timeout` <= 1, go to HOLD.
  - Otherwise counter <= counter + 1.
  - `rising_edge` in MEASURE is ignored. `falling_edge` wins over the timeout check in the same cycle.
- HOLD:
  - `width_valid` = 1.
  - `result_ready` = 1 -> IDLE. `width_valid` drops the next cycle and `overrun` clears.
  - A `rising_edge` while in HOLD without `result_ready` sets `overrun`.
  - A `rising_edge` in the same cycle as `result_ready` is also dropped and also sets `overrun`; the set has priority over the clear.
- Width arithmetic: if `rising_edge` is high at cycle r and `falling_edge` at cycle f, then `width` = f − r. The minimum is 1. The counter never wraps.
- Reset (`reset_n` low at a posedge), including mid-measurement:
  - State -> IDLE, counter = 0.
  - `width`, `width_valid`, `timeout`, `overrun`, `busy`, `period` and `period_valid` all 0.
  - Any edge present in the reset cycle is discarded.

## Timing
- `width_valid` rises 1 cycle after the `falling_edge` strobe, or 1 cycle after the cycle where counter == TIMEOUT_CYCLES.
- A new measurement can start no earlier than the cycle after the handshake (back in IDLE).
- `busy` is registered: it is high from cycle r+1 until the cycle the FSM enters HOLD.
- Upstream delivers edges 2–3 cycles after the pad transition. That latency is identical for both edges, so `width` is unaffected.

## Configuration
- Macro: `PULSE_WIDTH_METER_PERIOD_EN`.
- Defined:
  - A free-running period counter restarts at 1 on every `rising_edge`, in any state. It saturates at 2**COUNT_WIDTH − 1.
  - On each `rising_edge` after the first since reset: `period` <= counter value, and `period_valid` pulses high for 1 cycle (the next cycle).
  - The first rising edge after reset produces no strobe.
  - Period capture is independent of the width FSM and of `overrun`.
- Undefined:
  - `period` and `period_valid` are constant 0.
  - No period logic is synthesised.

## Test plan
- Width: reset, rising at cycle 10, falling at cycle 110, `result_ready` held 1 -> `width_valid` high at cycle 111 with `width` = 100, `timeout` = 0; `width_valid` low at 112.
- Timeout: `TIMEOUT_CYCLES` = 50, rising at cycle 10, no falling -> `width_valid` at cycle 61, `width` = 50, `timeout` = 1; a later falling edge is ignored.
- Hold and overrun:
  - Setup: `result_ready` = 0, measure a width of 20.
  - Issue a second rising edge while in HOLD -> `width` stays 20 and `overrun` = 1.
  - Assert `result_ready` -> IDLE next cycle, `overrun` cleared.
- Boundaries:
  - Rising and falling in the same cycle in IDLE -> no measurement.
  - Falling on the cycle after rising -> `width` = 1.
  - Falling in the same cycle the counter hits the timeout -> `timeout` = 0.
- Reset mid-operation: `reset_n` low during MEASURE -> the next cycle shows all outputs 0 and `busy` = 0; a fresh edge pair then measures correctly.
- Period (macro defined): rising edges at cycles 10, 210, 410 -> `period_valid` at 211 and 411 with `period` = 200; no strobe after the edge at cycle 10.
